// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
// Shared types and helpers for the sudoku result reader.
//   status_t        : termination reason reported with the streamed grid
//   reader_state_t  : reader FSM states (also exported on the debug port)
//   digit_width()   : bits needed to carry digits 0..width in binary
// -----------------------------------------------------------------------------
package sudoku_pkg;

  typedef enum logic [1:0] {
    ST_SOLVED  = 2'd0,
    ST_FAIL    = 2'd1,
    ST_STALLED = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_WAIT   = 2'd1,
    RD_STREAM = 2'd2,
    RD_DONE   = 2'd3
  } reader_state_t;

  function automatic int digit_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// -----------------------------------------------------------------------------
// onehot_to_bin
// Converts one sudoku cell (one-hot digit, 0 = undetermined) to a binary digit.
// Ports:
//   i_cell  in  WIDTH          one-hot cell value
//   o_digit out digit_width()  k+1 for a single set bit k, 0 when empty or bad
//   o_bad   out 1              more than one bit set
// -----------------------------------------------------------------------------
module onehot_to_bin
  import sudoku_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0]              i_cell,
  output logic [digit_width(WIDTH)-1:0] o_digit,
  output logic                          o_bad
);

  localparam int DW = digit_width(WIDTH);

  logic [DW-1:0] w_pos;
  logic          w_multi;

  // Position of the highest set bit; only meaningful when exactly one is set.
  always_comb begin
    w_pos = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i_cell[k]) w_pos = DW'(k + 1);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(i_cell & (i_cell - WIDTH'(1)));

  assign o_bad   = w_multi;
  assign o_digit = w_multi ? '0 : w_pos;

endmodule

// File: rtl/sudoku_result_reader.sv
// -----------------------------------------------------------------------------
// sudoku_result_reader
// Watches the solver's one-hot grid after a launch, decides when the solve has
// terminated (solved / fail / stalled / optional timeout), snapshots the grid
// and streams it row-major, one binary digit per beat.
//
// Optional feature macro: SUDOKU_READER_TIMEOUT_EN
//   defined   -> WAIT gives up after TIMEOUT_CYCLES cycles with status TIMEOUT
//   undefined -> no timeout counter; WAIT lasts until fail/solved/stalled
//
// Handshake: a beat transfers on a rising clock edge where o_out_valid and
// i_out_ready are both high; while o_out_valid is high and i_out_ready low,
// every beat output holds its value. o_out_valid never drops mid-stream.
//
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_start            launch pulse (honoured in IDLE, restarts WAIT)
//   i_final_vals       live solver grid, packed [row][col][bit]
//   i_fail             solver contradiction flag
//   o_out_valid/i_out_ready  beat handshake
//   o_out_digit        binary digit, 0 = empty or bad cell
//   o_out_row/o_out_col coordinates of the current beat
//   o_out_last         beat for the bottom-right cell
//   o_out_bad          current cell had several bits set
//   o_status           termination reason, held until next stream
//   o_busy             high in WAIT and STREAM
//   o_done             one-cycle pulse after the last beat transfers
//   o_dbg_state        current FSM state (reader_state_t encoding)
// -----------------------------------------------------------------------------
module sudoku_result_reader
  import sudoku_pkg::*;
#(
  parameter int WIDTH          = 9,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic [WIDTH*WIDTH*WIDTH-1:0]     i_final_vals,
  input  logic                             i_fail,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [digit_width(WIDTH)-1:0]    o_out_digit,
  output logic [$clog2(WIDTH)-1:0]         o_out_row,
  output logic [$clog2(WIDTH)-1:0]         o_out_col,
  output logic                             o_out_last,
  output logic                             o_out_bad,
  output logic [1:0]                       o_status,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [1:0]                       o_dbg_state
);

  localparam int CELLS = WIDTH * WIDTH;
  localparam int GW    = CELLS * WIDTH;
  localparam int DW    = digit_width(WIDTH);
  localparam int PW    = $clog2(WIDTH);
  localparam int SW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] POS_LAST    = PW'(WIDTH - 1);

  reader_state_t r_state;
  reader_state_t w_next_state;
  logic [GW-1:0] r_snap;
  logic [GW-1:0] r_prev;
  logic [SW-1:0] r_stable_cnt;
  logic [PW-1:0] r_row;
  logic [PW-1:0] r_col;
  status_t       r_status;

  logic          w_solved;
  logic          w_same;
  logic          w_stalled;
  logic          w_timeout;
  logic          w_term;
  status_t       w_term_status;
  logic          w_last;
  logic [WIDTH-1:0] w_cell;
  logic [DW-1:0] w_digit;
  logic          w_bad;

  // ---------------------------------------------------------------------------
  // Termination detection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_solved = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      if (i_final_vals[i*WIDTH +: WIDTH] == '0) w_solved = 1'b0;
    end
  end

  assign w_same = (i_final_vals == r_prev);
  // The counter holds the number of earlier unchanged cycles, so this cycle
  // being unchanged too completes the run.
  assign w_stalled = w_same && (r_stable_cnt == STABLE_LAST);

`ifdef SUDOKU_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo_cnt;

  // Counts WAIT cycles already spent; zero on the first WAIT cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != RD_WAIT || i_start) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_tmo_cnt == TIMEOUT_LAST);
`else
  // No timeout in this build; the parameter only keeps the interface uniform.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Priority: fail > solved > stalled > timeout.
  always_comb begin
    w_term        = 1'b1;
    w_term_status = ST_SOLVED;
    if (i_fail) begin
      w_term_status = ST_FAIL;
    end else if (w_solved) begin
      w_term_status = ST_SOLVED;
    end else if (w_stalled) begin
      w_term_status = ST_STALLED;
    end else if (w_timeout) begin
      w_term_status = ST_TIMEOUT;
    end else begin
      w_term = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= RD_IDLE;
    else         r_state <= w_next_state;
  end

  assign w_last = (r_row == POS_LAST) && (r_col == POS_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RD_IDLE:   if (i_start) w_next_state = RD_WAIT;
      RD_WAIT:   if (!i_start && w_term) w_next_state = RD_STREAM;
      RD_STREAM: if (i_out_ready && w_last) w_next_state = RD_DONE;
      RD_DONE:   w_next_state = RD_IDLE;
      default:   w_next_state = RD_IDLE;
    endcase
  end

  always_comb begin
    o_out_valid = 1'b0;
    o_out_digit = '0;
    o_out_row   = '0;
    o_out_col   = '0;
    o_out_last  = 1'b0;
    o_out_bad   = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      RD_WAIT: o_busy = 1'b1;
      RD_STREAM: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_digit = w_digit;
        o_out_row   = r_row;
        o_out_col   = r_col;
        o_out_last  = w_last;
        o_out_bad   = w_bad;
      end
      RD_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_status    = r_status;
  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Datapath: previous grid, stable counter, snapshot, stream position
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_snap       <= '0;
      r_prev       <= '0;
      r_stable_cnt <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_status     <= ST_SOLVED;
    end else begin
      case (r_state)
        RD_IDLE: begin
          r_prev       <= '0;
          r_stable_cnt <= '0;
          r_row        <= '0;
          r_col        <= '0;
        end
        RD_WAIT: begin
          if (i_start) begin
            // Relaunch: behave exactly like a fresh entry from IDLE.
            r_prev       <= '0;
            r_stable_cnt <= '0;
          end else begin
            r_prev       <= i_final_vals;
            r_stable_cnt <= w_same ? r_stable_cnt + SW'(1) : '0;
            if (w_term) begin
              r_snap   <= i_final_vals;
              r_status <= w_term_status;
              r_row    <= '0;
              r_col    <= '0;
            end
          end
        end
        RD_STREAM: begin
          if (i_out_ready) begin
            if (r_col == POS_LAST) begin
              r_col <= '0;
              r_row <= r_row + PW'(1);
            end else begin
              r_col <= r_col + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Select the snapshot cell addressed by the current stream position.
  always_comb begin
    w_cell = '0;
    for (int r = 0; r < WIDTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (r_row == PW'(r) && r_col == PW'(c)) w_cell = r_snap[(r*WIDTH + c)*WIDTH +: WIDTH];
      end
    end
  end

  onehot_to_bin #(
    .WIDTH(WIDTH)
  ) u_cvt (
    .i_cell (w_cell),
    .o_digit(w_digit),
    .o_bad  (w_bad)
  );

endmodule
